universal_counter_nd: RTL and testbench
=======================================

// Module: universal_counter_nd
// PURPOSE
//  Parametrised multi-digit up/down counter; successor to the single-nibble universal counter.
//  NDIGITS cascaded 4-bit digits, each counting hex (mode=1) or decimal/BCD (mode=0).
//  Adds parallel load, registered wrap pulse (carry) and terminal-count flag for chaining.
//  Used as timer/event counter feeding display and comparator logic.
// PARAMETERS
//  NDIGITS  4  number of 4-bit digits; count width = 4*NDIGITS (>=1)
// PORTS
//  clk       in   1           clock, all state updates on posedge
//  clear     in   1           synchronous active-high reset
//  mode      in   1           1 = hex digits (0..F), 0 = decimal digits (0..9)
//  incr      in   1           1 = count up, 0 = count down
//  pause     in   1           1 = hold count (load still honoured)
//  load      in   1           1 = parallel load load_val at next edge
//  load_val  in   4*NDIGITS   value for load, digit i = bits [4i+3:4i]
//  count     out  4*NDIGITS   counter value, registered
//  carry     out  1           registered; 1 for the cycle after a full-width wrap step
//  tc        out  1           combinational terminal count for current direction/mode
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high on clear: count<=0, carry<=0.
//  - Priority per edge: clear > load > pause > count step.
//  - load: count<=load_val verbatim (no BCD check), carry<=0; ignores pause/incr.
//  - pause=1 (no clear/load): count holds, carry<=0.
//  - Step: digit 0 always steps; digit i steps only when digits 0..i-1 all at limit
//    (up: limit = F hex / 9 dec; down: limit = 0). Single-cycle ripple, 1-edge latency.
//  - Up, hex:  digit F->0 with carry to next; else +1.
//  - Up, dec:  digit >=9 -> 0 with carry (A..F treated as 9); else +1.
//  - Down, hex: digit 0->F with borrow; else -1.
//  - Down, dec: digit 0->9 with borrow; digit >9 -> 9 (no borrow); else -1.
//  - Full wrap: up from all-limit (FF..F / 99..9) -> 0; down from 0 -> all-F / all-9.
//    carry<=1 on that edge only, else carry<=0 on every step edge.
//  - tc = incr ? (every digit at up-limit for mode) : (count==0). Independent of pause/load.
//    In dec mode up-limit means digit >=9.
//  - mode/incr may change any cycle; new values take effect at the next edge, no state kept.
//  - clear mid-count or coincident with load/wrap: clear wins, carry=0.
// CONFIGURATION
//  - COUNTER_SAT_EN defined: at full wrap point the counter saturates instead of wrapping:
//    up at all-limit holds value, down at 0 holds 0; carry stays 0; tc still asserted.
//  - COUNTER_SAT_EN undefined: wrap-around as above, carry pulses.
// TESTING
//  1. NDIGITS=4, clear=1 one edge -> count=0000, carry=0; tc=1 with incr=0.
//  2. mode=0,incr=1, load 0x0998, 2 steps -> 0999 then 1000, carry=0 throughout.
//  3. mode=1,incr=1, load 0xFFFF, 1 step -> 0000, carry=1 for one cycle, next step carry=0.
//  4. mode=0,incr=0 from 0000, 1 step -> 9999, carry=1; pause=1 3 cycles -> holds 9999, carry=0.
//  5. mode=0,incr=0, load 0x00C0, 1 step -> 00BF?no: digit0 0->9 borrows, digit1 C->9 -> 0099.
//  6. COUNTER_SAT_EN, mode=1,incr=1, load FFFF, 3 steps -> stays FFFF, carry=0, tc=1;
//     load+clear same edge -> 0000.

Source files
------------

// File: rtl/universal_counter_nd.sv
// Multi-digit hex/BCD up/down counter with parallel load, wrap pulse and terminal count.
// Optional build macro COUNTER_SAT_EN: saturate at the full-wrap point instead of wrapping.
module universal_counter_nd #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   mode,
  input  logic                   incr,
  input  logic                   pause,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_val,
  output logic [4*NDIGITS-1:0]   count,
  output logic                   carry,
  output logic                   tc
);

  localparam int W = 4 * NDIGITS;

  // A digit is "at limit" when stepping it would propagate to the next digit.
  function automatic logic at_limit(input logic [3:0] d, input logic hex, input logic up);
    logic r;
    if (up) r = hex ? (d == 4'hF) : (d >= 4'd9);
    else    r = (d == 4'd0);
    return r;
  endfunction

  // Non-BCD digits in decimal mode collapse onto 9 (up: treated as 9, down: load 9).
  function automatic logic [3:0] step_digit(input logic [3:0] d, input logic hex, input logic up);
    logic [3:0] r;
    if (up) begin
      if (hex)             r = d + 4'd1;
      else if (d >= 4'd9)  r = 4'd0;
      else                 r = d + 4'd1;
    end else begin
      if (hex)             r = d - 4'd1;
      else if (d == 4'd0)  r = 4'd9;
      else if (d > 4'd9)   r = 4'd9;
      else                 r = d - 4'd1;
    end
    return r;
  endfunction

  logic [W-1:0]       cnt_p1;
  logic               carry_p1;
  logic [W-1:0]       nxt_p0;
  logic [NDIGITS:0]   en_p0;
  logic               wrap_p0;

  always_comb begin
    nxt_p0   = cnt_p1;
    en_p0    = '0;
    en_p0[0] = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (en_p0[i]) nxt_p0[4*i +: 4] = step_digit(cnt_p1[4*i +: 4], mode, incr);
      en_p0[i+1] = en_p0[i] & at_limit(cnt_p1[4*i +: 4], mode, incr);
    end
    wrap_p0 = en_p0[NDIGITS];
  end

  // ---- stage p1: count / carry registers ----
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_p1   <= '0;
      carry_p1 <= 1'b0;
    end else if (load) begin
      cnt_p1   <= load_val;
      carry_p1 <= 1'b0;
    end else if (pause) begin
      carry_p1 <= 1'b0;
    end else begin
`ifdef COUNTER_SAT_EN
      if (!wrap_p0) cnt_p1 <= nxt_p0;
      carry_p1 <= 1'b0;
`else
      cnt_p1   <= nxt_p0;
      carry_p1 <= wrap_p0;
`endif
    end
  end

  assign count = cnt_p1;
  assign carry = carry_p1;
  // Every digit at its limit is exactly the full-wrap condition in both directions.
  assign tc    = wrap_p0;

endmodule

// File: tb/tb_universal_counter_nd.sv
// Randomized self-checking bench for universal_counter_nd against an arithmetic/ripple reference model.
module tb_universal_counter_nd;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         clear = 1'b0, mode = 1'b0, incr = 1'b0, pause = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         carry, tc;

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0] m_cnt = '0;
  logic         m_carry = 1'b0;
  logic         m_valid = 1'b0;

  universal_counter_nd #(.NDIGITS(N)) dut (
    .clk(clk), .clear(clear), .mode(mode), .incr(incr), .pause(pause),
    .load(load), .load_val(load_val), .count(count), .carry(carry), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  // Decimal step as a sequential digit ripple; returns whether it rippled off the top.
  function automatic logic [W-1:0] dec_step(input logic [W-1:0] v, input logic up, output logic wrapped);
    logic       go;
    logic [3:0] d;
    go = 1'b1;
    for (int i = 0; i < N && go; i++) begin
      d = v[4*i +: 4];
      if (up) begin
        if (d >= 4'd9) d = 4'd0;
        else begin d = d + 4'd1; go = 1'b0; end
      end else begin
        if (d == 4'd0) d = 4'd9;
        else if (d > 4'd9) begin d = 4'd9; go = 1'b0; end
        else begin d = d - 4'd1; go = 1'b0; end
      end
      v[4*i +: 4] = d;
    end
    wrapped = go;
    return v;
  endfunction

  function automatic logic model_tc(input logic [W-1:0] v, input logic hex, input logic up);
    logic r;
    if (!up) r = (v == '0);
    else if (hex) r = (v == '1);
    else begin
      r = 1'b1;
      for (int i = 0; i < N; i++) if (v[4*i +: 4] < 4'd9) r = 1'b0;
    end
    return r;
  endfunction

  task automatic cycle(input logic c, input logic ld, input logic p, input logic md,
                       input logic inc, input logic [W-1:0] lv);
    logic [W-1:0] nv;
    logic         wr;
    clear = c; load = ld; pause = p; mode = md; incr = inc; load_val = lv;
    #1;
    if (m_valid) chk("tc", {31'd0, tc}, {31'd0, model_tc(m_cnt, md, inc)});
    if (c) begin
      nv = '0; wr = 1'b0; m_valid = 1'b1;
      m_cnt = nv; m_carry = 1'b0;
    end else if (ld) begin
      m_cnt = lv; m_carry = 1'b0; m_valid = 1'b1;
    end else if (p) begin
      m_carry = 1'b0;
    end else begin
      if (md) begin
        wr = inc ? (m_cnt == '1) : (m_cnt == '0);
        nv = inc ? m_cnt + 1'b1 : m_cnt - 1'b1;
      end else begin
        nv = dec_step(m_cnt, inc, wr);
      end
`ifdef COUNTER_SAT_EN
      if (!wr) m_cnt = nv;
      m_carry = 1'b0;
`else
      m_cnt = nv;
      m_carry = wr;
`endif
    end
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("count", {16'd0, count}, {16'd0, m_cnt});
      chk("carry", {31'd0, carry}, {31'd0, m_carry});
    end
  endtask

  logic [W-1:0] lv;
  initial begin
    @(posedge clk);
    #1;
    // Reset; tc with incr=0 must then be high.
    cycle(1, 0, 0, 0, 0, '0);
    chk("rst_count", {16'd0, count}, 32'h0);
    chk("rst_carry", {31'd0, carry}, 32'h0);
    #1 chk("rst_tc", {31'd0, tc}, 32'h1);
    // Decimal up across 0999 -> 1000.
    cycle(0, 1, 0, 0, 1, 16'h0998);
    cycle(0, 0, 0, 0, 1, '0);
    chk("dec_0999", {16'd0, count}, 32'h0999);
    cycle(0, 0, 0, 0, 1, '0);
    chk("dec_1000", {16'd0, count}, 32'h1000);
    chk("dec_1000_c", {31'd0, carry}, 32'h0);
    // Hex wrap from FFFF.
    cycle(0, 1, 0, 1, 1, 16'hFFFF);
    cycle(0, 0, 0, 1, 1, '0);
`ifdef COUNTER_SAT_EN
    chk("hex_sat", {16'd0, count}, 32'hFFFF);
    chk("hex_sat_c", {31'd0, carry}, 32'h0);
    cycle(0, 0, 0, 1, 1, '0);
    cycle(0, 0, 0, 1, 1, '0);
    chk("hex_sat3", {16'd0, count}, 32'hFFFF);
    #1 chk("hex_sat_tc", {31'd0, tc}, 32'h1);
    cycle(1, 1, 0, 1, 1, 16'h1234);
    chk("clr_over_ld", {16'd0, count}, 32'h0);
`else
    chk("hex_wrap", {16'd0, count}, 32'h0000);
    chk("hex_wrap_c", {31'd0, carry}, 32'h1);
    cycle(0, 0, 0, 1, 1, '0);
    chk("hex_wrap_c2", {31'd0, carry}, 32'h0);
    // Decimal down wrap from 0000, then pause holds.
    cycle(1, 0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 0, '0);
    chk("dec_down_wrap", {16'd0, count}, 32'h9999);
    chk("dec_down_c", {31'd0, carry}, 32'h1);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 0, '0);
    chk("pause_hold", {16'd0, count}, 32'h9999);
    chk("pause_c", {31'd0, carry}, 32'h0);
`endif
    // Decimal down with non-BCD digit.
    cycle(0, 1, 0, 0, 0, 16'h00C0);
    cycle(0, 0, 0, 0, 0, '0);
    chk("dec_nonbcd", {16'd0, count}, 32'h0099);
    // Randomized run, biased toward wrap points.
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 3))
        0:       lv = 16'hFFFF;
        1:       lv = 16'h9999;
        2:       lv = {4{4'($urandom_range(8, 15))}};
        default: lv = 16'($urandom);
      endcase
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom), lv);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
